hqm_aqed_pri_sched: RTL and testbench

HQM_AQED_PRI_SCHED -- requirements
Module: hqm_aqed_pri_sched

---
 rtl/hqm_aqed_pri_sched_pkg.sv | 20 ++
 rtl/hqm_aqed_pri_sched_if.sv | 30 +++
 rtl/hqm_aqed_pri_sel.sv | 30 +++
 rtl/hqm_aqed_pri_sched.sv | 183 ++++++++++++++++++
 tb/tb_hqm_aqed_pri_sched.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hqm_aqed_pri_sched_pkg.sv
// Shared types for the AQED priority scheduler: priority count, priority
// index type, FSM state encoding and WRR weight type.
package hqm_aqed_pkg;

  localparam int HQM_AQED_NUM_PRI = 4;

  typedef logic [1:0] pri_t;
  typedef logic [3:0] wt_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // A programmed weight of zero still grants one pop per round.
  function automatic wt_t eff_wt(input wt_t w);
    return (w == '0) ? wt_t'(1) : w;
  endfunction

endpackage

// File: rtl/hqm_aqed_pri_sched_if.sv
// Enqueue / pop request / pop response bundle for hqm_aqed_pri_sched.
// master: traffic source (drives enq/pop), slave: the scheduler.
interface hqm_aqed_pri_sched_if
  import hqm_aqed_pkg::*;
#(
  parameter int NUM_QID = 32
);
  localparam int QW = $clog2(NUM_QID);

  logic          enq_v;
  logic [QW-1:0] enq_qid;
  pri_t          enq_pri;
  logic          pop_v;
  logic [QW-1:0] pop_qid;
  logic          pop_ready;
  logic          pop_rsp_v;
  pri_t          pop_rsp_pri;
  logic          pop_rsp_hit;

  modport master (
    output enq_v, enq_qid, enq_pri, pop_v, pop_qid,
    input  pop_ready, pop_rsp_v, pop_rsp_pri, pop_rsp_hit
  );

  modport slave (
    input  enq_v, enq_qid, enq_pri, pop_v, pop_qid,
    output pop_ready, pop_rsp_v, pop_rsp_pri, pop_rsp_hit
  );

endinterface

// File: rtl/hqm_aqed_pri_sel.sv
// Combinational priority selector. Picks the lowest non-empty priority that
// still has credit; if every non-empty priority is out of credit it flags a
// reload and picks as though all credits were refilled. With crd_ok tied to
// all-ones this is a plain strict-priority encoder.
module hqm_aqed_pri_sel
  import hqm_aqed_pkg::*;
(
  input  logic [HQM_AQED_NUM_PRI-1:0] ne,
  input  logic [HQM_AQED_NUM_PRI-1:0] crd_ok,
  output pri_t                        pri,
  output logic                        hit,
  output logic                        reload
);

  logic [HQM_AQED_NUM_PRI-1:0] elig;
  logic [HQM_AQED_NUM_PRI-1:0] cand;

  // Lowest set bit of the candidate vector wins; pri stays 0 on a miss.
  always_comb begin
    elig   = ne & crd_ok;
    reload = (ne != '0) && (elig == '0);
    cand   = reload ? ne : elig;
    hit    = (cand != '0);
    pri    = '0;
    for (int p = HQM_AQED_NUM_PRI - 1; p >= 0; p--) begin
      if (cand[p]) pri = pri_t'(p);
    end
  end

endmodule

// File: rtl/hqm_aqed_pri_sched.sv
// Per-QID, per-priority occupancy tracker with pop-time priority selection.
// Counters are cleared by an INIT sweep (one QID per cycle) after reset or
// cfg_clr_req. Define HQM_AQED_PRI_WRR_EN for weighted round robin selection;
// otherwise selection is strict priority (pri0 highest).
module hqm_aqed_pri_sched
  import hqm_aqed_pkg::*;
#(
  parameter int NUM_QID = 32,
  parameter int CNT_W   = 12
) (
  input  logic                        hqm_gated_clk,
  input  logic                        hqm_gated_rst,
  hqm_aqed_pri_sched_if.slave         bus,
  input  logic                        cfg_clr_req,
  input  wt_t [HQM_AQED_NUM_PRI-1:0]  cfg_wrr_wt,
  output logic                        reset_done,
  output logic                        unit_idle,
  output logic                        err_ovf_v,
  output logic                        err_unf_v
);

  localparam int               QW       = $clog2(NUM_QID);
  localparam logic [QW-1:0]    IDX_LAST = QW'(NUM_QID - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                      state_q, state_d;
  logic [QW-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q [NUM_QID][HQM_AQED_NUM_PRI];
  logic [CNT_W-1:0]            cnt_d [NUM_QID][HQM_AQED_NUM_PRI];
  logic                        rsp_v_q, rsp_v_d;
  pri_t                        rsp_pri_q, rsp_pri_d;
  logic                        rsp_hit_q, rsp_hit_d;
  logic                        unf_q, unf_d;
  logic                        ovf;
  logic                        same;
  logic                        any_nz;
  logic [HQM_AQED_NUM_PRI-1:0] ne;
  logic [HQM_AQED_NUM_PRI-1:0] crd_ok;
  pri_t                        sel_pri;
  logic                        sel_hit;
  logic                        sel_reload;

`ifdef HQM_AQED_PRI_WRR_EN
  wt_t credit_q [HQM_AQED_NUM_PRI];
  wt_t credit_d [HQM_AQED_NUM_PRI];
`else
  logic unused_wrr;
  assign unused_wrr = ^{cfg_wrr_wt, sel_reload};
`endif

  // Non-empty vector for the QID being popped, plus credit availability.
  always_comb begin
    for (int p = 0; p < HQM_AQED_NUM_PRI; p++) begin
      ne[p] = (cnt_q[bus.pop_qid][p] != '0);
`ifdef HQM_AQED_PRI_WRR_EN
      crd_ok[p] = (credit_q[p] != '0);
`else
      crd_ok[p] = 1'b1;
`endif
    end
  end

  hqm_aqed_pri_sel u_sel (
    .ne     (ne),
    .crd_ok (crd_ok),
    .pri    (sel_pri),
    .hit    (sel_hit),
    .reload (sel_reload)
  );

  // Next-state: INIT sweep, pop selection/decrement, saturating enqueue.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rsp_v_d   = 1'b0;
    rsp_pri_d = '0;
    rsp_hit_d = 1'b0;
    unf_d     = 1'b0;
    ovf       = 1'b0;
    same      = 1'b0;
`ifdef HQM_AQED_PRI_WRR_EN
    credit_d  = credit_q;
`endif
    case (state_q)
      ST_INIT: begin
        for (int p = 0; p < HQM_AQED_NUM_PRI; p++) cnt_d[idx_q][p] = '0;
        unf_d = bus.enq_v;
        if (cfg_clr_req) begin
          idx_d = '0;
        end else if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_READY;
`ifdef HQM_AQED_PRI_WRR_EN
          for (int p = 0; p < HQM_AQED_NUM_PRI; p++) credit_d[p] = eff_wt(cfg_wrr_wt[p]);
`endif
        end else begin
          idx_d = idx_q + QW'(1);
        end
      end
      default: begin
        if (cfg_clr_req) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
        if (bus.pop_v) begin
          rsp_v_d   = 1'b1;
          rsp_hit_d = sel_hit;
          rsp_pri_d = sel_pri;
          if (sel_hit) begin
            cnt_d[bus.pop_qid][sel_pri] = cnt_q[bus.pop_qid][sel_pri] - CNT_W'(1);
`ifdef HQM_AQED_PRI_WRR_EN
            for (int p = 0; p < HQM_AQED_NUM_PRI; p++) begin
              credit_d[p] = sel_reload ? eff_wt(cfg_wrr_wt[p]) : credit_q[p];
            end
            credit_d[sel_pri] = credit_d[sel_pri] - wt_t'(1);
`endif
          end
        end
        if (bus.enq_v) begin
          same = bus.pop_v && sel_hit && (bus.pop_qid == bus.enq_qid) && (sel_pri == bus.enq_pri);
          // A matching pop hit cancels the increment, so the count holds.
          if (same) begin
            cnt_d[bus.enq_qid][bus.enq_pri] = cnt_q[bus.enq_qid][bus.enq_pri];
          end else if (cnt_q[bus.enq_qid][bus.enq_pri] == CNT_MAX) begin
            ovf = 1'b1;
          end else begin
            cnt_d[bus.enq_qid][bus.enq_pri] = cnt_q[bus.enq_qid][bus.enq_pri] + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // State, counters and registered response/error flops.
  always_ff @(posedge hqm_gated_clk or posedge hqm_gated_rst) begin
    if (hqm_gated_rst) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      rsp_v_q   <= 1'b0;
      rsp_pri_q <= '0;
      rsp_hit_q <= 1'b0;
      unf_q     <= 1'b0;
      for (int q = 0; q < NUM_QID; q++) begin
        for (int p = 0; p < HQM_AQED_NUM_PRI; p++) cnt_q[q][p] <= '0;
      end
`ifdef HQM_AQED_PRI_WRR_EN
      for (int p = 0; p < HQM_AQED_NUM_PRI; p++) credit_q[p] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rsp_v_q   <= rsp_v_d;
      rsp_pri_q <= rsp_pri_d;
      rsp_hit_q <= rsp_hit_d;
      unf_q     <= unf_d;
      cnt_q     <= cnt_d;
`ifdef HQM_AQED_PRI_WRR_EN
      credit_q  <= credit_d;
`endif
    end
  end

  // Idle means every counter is zero and no response is in flight.
  always_comb begin
    any_nz = 1'b0;
    for (int q = 0; q < NUM_QID; q++) begin
      for (int p = 0; p < HQM_AQED_NUM_PRI; p++) begin
        if (cnt_q[q][p] != '0) any_nz = 1'b1;
      end
    end
  end

  assign bus.pop_ready   = (state_q == ST_READY);
  assign bus.pop_rsp_v   = rsp_v_q;
  assign bus.pop_rsp_pri = rsp_pri_q;
  assign bus.pop_rsp_hit = rsp_hit_q;
  assign reset_done      = (state_q == ST_READY);
  assign unit_idle       = (state_q == ST_READY) && !any_nz && !rsp_v_q;
  assign err_ovf_v       = ovf;
  assign err_unf_v       = unf_q;

endmodule

// File: tb/tb_hqm_aqed_pri_sched.sv
// Directed self-checking bench for hqm_aqed_pri_sched (NUM_QID=32, CNT_W=12).
// Builds with or without HQM_AQED_PRI_WRR_EN; the WRR order test runs only
// when the macro is defined.
module tb_hqm_aqed_pri_sched;
  import hqm_aqed_pkg::*;

  logic      hqm_gated_clk = 1'b0;
  logic      hqm_gated_rst = 1'b1;
  logic      cfg_clr_req   = 1'b0;
  wt_t [3:0] cfg_wrr_wt    = {4'd1, 4'd1, 4'd1, 4'd2};
  logic      reset_done, unit_idle, err_ovf_v, err_unf_v;
  int        total = 0;
  int        bad   = 0;

  hqm_aqed_pri_sched_if #(.NUM_QID(32)) bus ();

  hqm_aqed_pri_sched #(.NUM_QID(32), .CNT_W(12)) dut (
    .hqm_gated_clk (hqm_gated_clk),
    .hqm_gated_rst (hqm_gated_rst),
    .bus           (bus),
    .cfg_clr_req   (cfg_clr_req),
    .cfg_wrr_wt    (cfg_wrr_wt),
    .reset_done    (reset_done),
    .unit_idle     (unit_idle),
    .err_ovf_v     (err_ovf_v),
    .err_unf_v     (err_unf_v)
  );

  always #5 hqm_gated_clk = ~hqm_gated_clk;

  task automatic tick();
    @(posedge hqm_gated_clk);
    #1;
  endtask

  task automatic enq_one(input int q, input int p);
    bus.enq_v   = 1'b1;
    bus.enq_qid = 5'(q);
    bus.enq_pri = 2'(p);
    tick();
    bus.enq_v   = 1'b0;
  endtask

  task automatic pop_one(input int q, output logic v, output pri_t pri, output logic hit);
    bus.pop_v   = 1'b1;
    bus.pop_qid = 5'(q);
    tick();
    bus.pop_v   = 1'b0;
    v   = bus.pop_rsp_v;
    pri = bus.pop_rsp_pri;
    hit = bus.pop_rsp_hit;
  endtask

  task automatic test_reset();
    int   n;
    logic rdy_seen;
    repeat (3) tick();
    total++; if ({bus.pop_ready, bus.pop_rsp_v, bus.pop_rsp_hit, reset_done, unit_idle} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {bus.pop_ready, bus.pop_rsp_v, bus.pop_rsp_hit, reset_done, unit_idle});
    end
    total++; if ({bus.pop_rsp_pri, err_ovf_v, err_unf_v} !== 4'b0) begin
      bad++; $display("FAIL reset_pri_err: got %b want 0000", {bus.pop_rsp_pri, err_ovf_v, err_unf_v});
    end
    hqm_gated_rst = 1'b0;
    n = 0; rdy_seen = 1'b0;
    while (!reset_done && n < 60) begin
      tick(); n++;
      if (!reset_done && bus.pop_ready) rdy_seen = 1'b1;
    end
    total++; if (n !== 32) begin bad++; $display("FAIL reset_done_latency: got %0d want 32", n); end
    total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL pop_ready_in_init: got %b want 0", rdy_seen); end
    total++; if (bus.pop_ready !== 1'b1) begin bad++; $display("FAIL pop_ready_after_init: got %b want 1", bus.pop_ready); end
    total++; if (unit_idle !== 1'b1) begin bad++; $display("FAIL idle_after_init: got %b want 1", unit_idle); end
  endtask

  task automatic test_strict_pop();
    int   exp_pri [5] = '{1, 2, 2, 2, 0};
    logic exp_hit [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic v, hit;
    pri_t pri;
    for (int k = 0; k < 3; k++) enq_one(5, 2);
    enq_one(5, 1);
    total++; if (unit_idle !== 1'b0) begin bad++; $display("FAIL idle_with_counts: got %b want 0", unit_idle); end
    for (int k = 0; k < 5; k++) begin
      pop_one(5, v, pri, hit);
      total++; if ({v, hit, pri} !== {1'b1, exp_hit[k], 2'(exp_pri[k])}) begin
        bad++; $display("FAIL strict_pop%0d: got v=%b hit=%b pri=%0d want v=1 hit=%b pri=%0d", k, v, hit, pri, exp_hit[k], exp_pri[k]);
      end
    end
    tick();
    total++; if (bus.pop_rsp_v !== 1'b0) begin bad++; $display("FAIL rsp_v_no_pop: got %b want 0", bus.pop_rsp_v); end
    total++; if (unit_idle !== 1'b1) begin bad++; $display("FAIL idle_after_pops: got %b want 1", unit_idle); end
  endtask

  task automatic test_same_cycle();
    logic v, hit;
    pri_t pri;
    // Empty counter: pop misses, enqueue still lands.
    bus.enq_v = 1'b1; bus.enq_qid = 5'd3; bus.enq_pri = 2'd0;
    pop_one(3, v, pri, hit);
    bus.enq_v = 1'b0;
    total++; if ({v, hit, pri} !== 4'b1000) begin bad++; $display("FAIL same_empty_pop: got v=%b hit=%b pri=%0d want v=1 hit=0 pri=0", v, hit, pri); end
    pop_one(3, v, pri, hit);
    total++; if ({v, hit, pri} !== 4'b1100) begin bad++; $display("FAIL same_empty_count1: got v=%b hit=%b pri=%0d want v=1 hit=1 pri=0", v, hit, pri); end
    pop_one(3, v, pri, hit);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL same_empty_count0: got hit=%b want 0", hit); end
    // Same pri hit: count held at 1.
    enq_one(7, 1);
    bus.enq_v = 1'b1; bus.enq_qid = 5'd7; bus.enq_pri = 2'd1;
    pop_one(7, v, pri, hit);
    bus.enq_v = 1'b0;
    total++; if ({v, hit, pri} !== 4'b1101) begin bad++; $display("FAIL same_hit_pop: got v=%b hit=%b pri=%0d want v=1 hit=1 pri=1", v, hit, pri); end
    pop_one(7, v, pri, hit);
    total++; if ({hit, pri} !== 3'b101) begin bad++; $display("FAIL same_hit_held: got hit=%b pri=%0d want hit=1 pri=1", hit, pri); end
    pop_one(7, v, pri, hit);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL same_hit_drained: got hit=%b want 0", hit); end
  endtask

  task automatic test_saturate();
    int   ovf_cnt = 0;
    int   ovf_at  = -1;
    int   hits    = 0;
    logic v, hit;
    pri_t pri;
    for (int i = 0; i < 4096; i++) begin
      bus.enq_v = 1'b1; bus.enq_qid = 5'd0; bus.enq_pri = 2'd3;
      #1;
      if (err_ovf_v === 1'b1) begin ovf_cnt++; ovf_at = i; end
      tick();
    end
    bus.enq_v = 1'b0;
    #1;
    total++; if (ovf_cnt !== 1 || ovf_at !== 4095) begin
      bad++; $display("FAIL ovf_pulse: got count=%0d at=%0d want count=1 at=4095", ovf_cnt, ovf_at);
    end
    total++; if (err_ovf_v !== 1'b0) begin bad++; $display("FAIL ovf_idle: got %b want 0", err_ovf_v); end
    for (int i = 0; i < 4095; i++) begin
      pop_one(0, v, pri, hit);
      if (v === 1'b1 && hit === 1'b1 && pri === 2'd3) hits++;
    end
    total++; if (hits !== 4095) begin bad++; $display("FAIL sat_count: got %0d want 4095", hits); end
    pop_one(0, v, pri, hit);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL sat_drained: got hit=%b want 0", hit); end
  endtask

  task automatic test_clear();
    int   n;
    logic v, hit;
    pri_t pri;
    enq_one(9, 0); enq_one(9, 0); enq_one(20, 3);
    cfg_clr_req = 1'b1; tick(); cfg_clr_req = 1'b0;
    total++; if ({reset_done, bus.pop_ready} !== 2'b00) begin bad++; $display("FAIL clr_enter_init: got %b want 00", {reset_done, bus.pop_ready}); end
    bus.enq_v = 1'b1; bus.enq_qid = 5'd9; bus.enq_pri = 2'd0;
    tick(); n = 1;
    bus.enq_v = 1'b0;
    total++; if (err_unf_v !== 1'b1) begin bad++; $display("FAIL unf_pulse: got %b want 1", err_unf_v); end
    tick(); n++;
    total++; if (err_unf_v !== 1'b0) begin bad++; $display("FAIL unf_clear: got %b want 0", err_unf_v); end
    while (!reset_done && n < 60) begin tick(); n++; end
    total++; if (n !== 32) begin bad++; $display("FAIL clr_latency: got %0d want 32", n); end
    pop_one(9, v, pri, hit);
    total++; if ({v, hit} !== 2'b10) begin bad++; $display("FAIL clr_q9: got v=%b hit=%b want v=1 hit=0", v, hit); end
    pop_one(20, v, pri, hit);
    total++; if ({v, hit} !== 2'b10) begin bad++; $display("FAIL clr_q20: got v=%b hit=%b want v=1 hit=0", v, hit); end
  endtask

  task automatic test_clear_restart();
    int n;
    cfg_clr_req = 1'b1; tick(); cfg_clr_req = 1'b0;
    n = 0;
    while (!reset_done && n < 80) begin
      if (n == 10) cfg_clr_req = 1'b1;
      tick(); n++;
      cfg_clr_req = 1'b0;
    end
    total++; if (n !== 43) begin bad++; $display("FAIL clr_restart_latency: got %0d want 43", n); end
  endtask

`ifdef HQM_AQED_PRI_WRR_EN
  task automatic test_wrr();
    int   exp_o [10] = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3};
    int   n;
    logic v, hit;
    pri_t pri;
    cfg_clr_req = 1'b1; tick(); cfg_clr_req = 1'b0;
    n = 0;
    while (!reset_done && n < 60) begin tick(); n++; end
    for (int p = 0; p < 4; p++) for (int k = 0; k < 10; k++) enq_one(1, p);
    for (int k = 0; k < 10; k++) begin
      pop_one(1, v, pri, hit);
      total++; if ({v, hit, pri} !== {2'b11, 2'(exp_o[k])}) begin
        bad++; $display("FAIL wrr_pop%0d: got v=%b hit=%b pri=%0d want v=1 hit=1 pri=%0d", k, v, hit, pri, exp_o[k]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_pop();
    int   n;
    logic v, hit;
    pri_t pri;
    enq_one(2, 1);
    bus.pop_v = 1'b1; bus.pop_qid = 5'd2;
    hqm_gated_rst = 1'b1;
    tick();
    bus.pop_v = 1'b0;
    total++; if ({bus.pop_rsp_v, bus.pop_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_mid_pop: got %b want 00", {bus.pop_rsp_v, bus.pop_ready});
    end
    hqm_gated_rst = 1'b0;
    n = 0;
    while (!reset_done && n < 60) begin
      tick(); n++;
    end
    total++; if (n !== 32) begin bad++; $display("FAIL reset2_latency: got %0d want 32", n); end
    pop_one(2, v, pri, hit);
    total++; if ({v, hit} !== 2'b10) begin bad++; $display("FAIL reset_cleared_q2: got v=%b hit=%b want v=1 hit=0", v, hit); end
  endtask

  initial begin
    bus.enq_v   = 1'b0;
    bus.enq_qid = '0;
    bus.enq_pri = '0;
    bus.pop_v   = 1'b0;
    bus.pop_qid = '0;
    test_reset();
    test_strict_pop();
    test_same_cycle();
    test_saturate();
    test_clear();
    test_clear_restart();
`ifdef HQM_AQED_PRI_WRR_EN
    test_wrr();
`endif
    test_reset_mid_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
